shared_mem_ctrl: RTL and testbench

Main-memory controller and arbiter on the cache side of the MSI system: it accepts block requests from N_PORTS cache instances over their mem_cs/mem_rd/mem_wr/mem_ready handshake. It grants one requester at a time and services the request against a 64-entry × 32-bit block store with fixed access latency. It pulses mem_ready back to the granted cache.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_port_arbiter.sv | 79 +++++++
 rtl/shared_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_shared_mem_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the shared-memory controller: storage geometry,
// controller FSM states and the latched operation type.
package mem_pkg;

  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    RECOVER
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  // A port is requesting only when selected and strobing an operation.
  function automatic logic is_request(input logic cs, input logic rd, input logic wr);
    return cs & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// One-hot arbiter for the shared-memory ports.
// Configuration macro: MEM_RR_ARB_EN
//   defined   -> round-robin; search starts at a pointer that moves to
//                (winner+1) mod N_PORTS on every grant.
//   undefined -> fixed priority, lowest index wins; no pointer state.
module mem_port_arbiter #(
  parameter  int N_PORTS = 2,
  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] i_req,
  input  logic [N_PORTS-1:0] i_mask,
  output logic [N_PORTS-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [N_PORTS-1:0] w_eff_req;

  assign w_eff_req = i_req & ~i_mask;
  assign o_valid   = |o_gnt;

`ifdef MEM_RR_ARB_EN

  logic [IDX_W-1:0] r_ptr;

  // Round-robin search: first eligible port at or after the pointer.
  always_comb begin
    int   v_pos;
    logic v_found;
    o_gnt   = '0;
    o_idx   = '0;
    v_pos   = 0;
    v_found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      v_pos = int'(r_ptr) + k;
      if (v_pos >= N_PORTS) v_pos = v_pos - N_PORTS;
      if (!v_found && w_eff_req[v_pos]) begin
        v_found      = 1'b1;
        o_gnt[v_pos] = 1'b1;
        o_idx        = IDX_W'(v_pos);
      end
    end
  end

  // Pointer moves just past the winner on every issued grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_idx == IDX_W'(N_PORTS - 1)) ? '0 : o_idx + 1'b1;
    end
  end

`else

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    logic v_found;
    o_gnt   = '0;
    o_idx   = '0;
    v_found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!v_found && w_eff_req[k]) begin
        v_found  = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IDX_W'(k);
      end
    end
  end

  // Clock and reset are only needed by the round-robin pointer.
  logic w_unused;
  assign w_unused = &{1'b0, clk, reset};

`endif

endmodule

// File: rtl/shared_mem_ctrl.sv
// Main-memory controller and arbiter for N_PORTS caches. One transaction at a
// time against a 64 x 32-bit block store with a fixed LATENCY access time.
// Configuration macro: MEM_RR_ARB_EN (round-robin arbitration when defined,
// fixed lowest-index priority otherwise).
module shared_mem_ctrl
  import mem_pkg::*;
#(
  parameter  int N_PORTS = 2,
  parameter  int LATENCY = 3,
  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_PORTS-1:0]              mem_cs,
  input  logic [N_PORTS-1:0]              mem_rd,
  input  logic [N_PORTS-1:0]              mem_wr,
  input  logic [MEM_ADDR_W*N_PORTS-1:0]   mem_addr,
  input  logic [MEM_DATA_W*N_PORTS-1:0]   mem_wdata,
  output logic [MEM_DATA_W-1:0]           mem_rdata,
  output logic [N_PORTS-1:0]              mem_ready,
  output logic [N_PORTS-1:0]              mem_gnt
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [MEM_DATA_W-1:0] r_wdata;
  op_t                   r_op;
  logic [N_PORTS-1:0]    r_gnt;
  logic [MEM_DATA_W-1:0] r_rdata;
  logic [MEM_DATA_W-1:0] r_mem [MEM_DEPTH];

  logic [N_PORTS-1:0]    w_req;
  logic [N_PORTS-1:0]    w_arb_req;
  logic [N_PORTS-1:0]    w_mask;
  logic [N_PORTS-1:0]    w_arb_gnt;
  logic [IDX_W-1:0]      w_arb_idx;
  logic                  w_arb_valid;
  logic                  w_commit;
  logic [MEM_ADDR_W-1:0] w_addr_arr  [N_PORTS];
  logic [MEM_DATA_W-1:0] w_wdata_arr [N_PORTS];

  // Unpack the flat per-port buses and qualify requests.
  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign w_addr_arr[g]  = mem_addr[g*MEM_ADDR_W +: MEM_ADDR_W];
    assign w_wdata_arr[g] = mem_wdata[g*MEM_DATA_W +: MEM_DATA_W];
    assign w_req[g]       = is_request(mem_cs[g], mem_rd[g], mem_wr[g]);
  end

  // In RECOVER the just-served port is hidden so a late mem_cs drop is not
  // re-served; arbitration only happens in IDLE and RECOVER.
  always_comb begin
    w_mask = '0;
    if (r_state == RECOVER) w_mask[r_idx] = 1'b1;
    w_arb_req = (r_state == IDLE || r_state == RECOVER) ? w_req : '0;
  end

  mem_port_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_arbiter (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_arb_req),
    .i_mask  (w_mask),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_commit = (r_state == ACCESS) && (r_cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and ready pulse.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    w_state_nxt = r_state;
    mem_ready   = '0;
    unique case (r_state)
      IDLE:    if (w_arb_valid) w_state_nxt = ACCESS;
      ACCESS:  if (r_cnt == '0) w_state_nxt = RESP;
      RESP: begin
        mem_ready[r_idx] = 1'b1;
        w_state_nxt      = RECOVER;
      end
      RECOVER: w_state_nxt = w_arb_valid ? ACCESS : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transaction latches, latency counter, grant and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= OP_RD;
      r_gnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_arb_valid) begin
        r_idx   <= w_arb_idx;
        r_addr  <= w_addr_arr[w_arb_idx];
        r_wdata <= w_wdata_arr[w_arb_idx];
        r_op    <= mem_wr[w_arb_idx] ? OP_WR : OP_RD;
        r_gnt   <= w_arb_gnt;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if (r_state == ACCESS && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_commit) begin
        r_rdata <= (r_op == OP_WR) ? r_wdata : r_mem[r_addr];
      end

      if (r_state == RESP) r_gnt <= '0;
    end
  end

  // Block store write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; a reset branch would turn it
    // into thousands of flops instead of a RAM. A reset before the commit edge
    // leaves r_state != ACCESS, so the pending write is dropped.
    if (w_commit && r_op == OP_WR) r_mem[r_addr] <= r_wdata;
  end

  assign mem_rdata = r_rdata;
  assign mem_gnt   = r_gnt;

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed self-checking bench for shared_mem_ctrl (N_PORTS=2, LATENCY=3).
module tb_shared_mem_ctrl;

  localparam int N   = 2;
  localparam int LAT = 3;

  logic            clk;
  logic            reset;
  logic [N-1:0]    mem_cs;
  logic [N-1:0]    mem_rd;
  logic [N-1:0]    mem_wr;
  logic [6*N-1:0]  mem_addr;
  logic [32*N-1:0] mem_wdata;
  logic [31:0]     mem_rdata;
  logic [N-1:0]    mem_ready;
  logic [N-1:0]    mem_gnt;

  int n_total = 0;
  int n_bad   = 0;

  shared_mem_ctrl #(
    .N_PORTS (N),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cs    (mem_cs),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_gnt   (mem_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic cs, input logic rd, input logic wr,
                          input logic [5:0] addr, input logic [31:0] data);
    mem_cs[p]            = cs;
    mem_rd[p]            = rd;
    mem_wr[p]            = wr;
    mem_addr[p*6 +: 6]   = addr;
    mem_wdata[p*32 +: 32] = data;
  endtask

  // Single transaction from IDLE: request in cycle 0, ready expected in
  // cycle LAT+1, grant held from cycle 1, grant low in RECOVER.
  task automatic txn(input string tag, input int p, input logic rd, input logic wr,
                     input logic [5:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_rdata);
    int cyc;
    set_port(p, 1'b1, rd, wr, addr, data);
    check({tag, "_gnt_c0"}, 32'(mem_gnt), 32'h0);
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) check({tag, "_gnt_c1"}, 32'(mem_gnt), 32'(1 << p));
      if (mem_ready != '0) break;
    end
    check({tag, "_ready_cycle"}, 32'(cyc), 32'(LAT + 1));
    check({tag, "_ready"}, 32'(mem_ready), 32'(1 << p));
    check({tag, "_rdata"}, mem_rdata, exp_rdata);
    set_port(p, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
    tick();
    check({tag, "_gnt_recover"}, 32'(mem_gnt), 32'h0);
    tick();
  endtask

  initial begin : stimulus
    int cyc;
    int n_seen;
    int bad_cnt;
    logic [31:0] exp_rd [4];

    reset     = 1'b1;
    mem_cs    = '0;
    mem_rd    = '0;
    mem_wr    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    repeat (3) tick();
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_gnt", 32'(mem_gnt), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // Write then read back through port 0.
    txn("wr05", 0, 1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 32'hDEADBEEF);
    txn("rd05", 0, 1'b1, 1'b0, 6'h05, 32'h0, 32'hDEADBEEF);

    // Both strobes high is a write.
    txn("rdwr10", 1, 1'b1, 1'b1, 6'h10, 32'hA5A5A5A5, 32'hA5A5A5A5);
    txn("rd10", 0, 1'b1, 1'b0, 6'h10, 32'h0, 32'hA5A5A5A5);

    // Contention: reset first so any round-robin pointer restarts at port 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    exp_rd[0] = 32'hDEADBEEF;
    exp_rd[1] = 32'hA5A5A5A5;
    exp_rd[2] = 32'hDEADBEEF;
    exp_rd[3] = 32'hA5A5A5A5;
    set_port(0, 1'b1, 1'b1, 1'b0, 6'h05, 32'h0);
    set_port(1, 1'b1, 1'b1, 1'b0, 6'h10, 32'h0);
    n_seen = 0;
    cyc    = 0;
    while (cyc < 40 && n_seen < 4) begin
      tick();
      cyc++;
      if (cyc == 1) check("arb_gnt_c1", 32'(mem_gnt), 32'h1);
      if (cyc == 6) check("arb_gnt_c6", 32'(mem_gnt), 32'h2);
      if (mem_ready != '0) begin
        check($sformatf("arb_ready%0d", n_seen), 32'(mem_ready), 32'(1 << (n_seen % 2)));
        check($sformatf("arb_cycle%0d", n_seen), 32'(cyc), 32'((LAT + 1) + n_seen * (LAT + 2)));
        check($sformatf("arb_rdata%0d", n_seen), mem_rdata, exp_rd[n_seen]);
        n_seen++;
      end
    end
    check("arb_count", 32'(n_seen), 32'd4);
    set_port(0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
    repeat (3) tick();

    // Late drop: port 0 keeps mem_cs through RECOVER; no second transaction.
    set_port(0, 1'b1, 1'b0, 1'b1, 6'h20, 32'hCAFEF00D);
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (mem_ready != '0) break;
    end
    check("late_ready_cycle", 32'(cyc), 32'(LAT + 1));
    tick();
    check("late_gnt_recover", 32'(mem_gnt), 32'h0);
    set_port(0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
    bad_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mem_ready != '0 || mem_gnt != '0) bad_cnt++;
    end
    check("late_no_reserve", 32'(bad_cnt), 32'h0);
    txn("rd20", 1, 1'b1, 1'b0, 6'h20, 32'h0, 32'hCAFEF00D);

    // Reset during ACCESS cycle 1 of a write to 0x3F.
    set_port(0, 1'b1, 1'b0, 1'b1, 6'h3F, 32'h12345678);
    tick();
    check("rstop_gnt_before", 32'(mem_gnt), 32'h1);
    reset = 1'b1;
    #1;
    check("rstop_gnt", 32'(mem_gnt), 32'h0);
    check("rstop_ready", 32'(mem_ready), 32'h0);
    check("rstop_rdata", mem_rdata, 32'h0);
    set_port(0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
    bad_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (mem_ready != '0) bad_cnt++;
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mem_ready != '0) bad_cnt++;
    end
    check("rstop_no_ready", 32'(bad_cnt), 32'h0);
    txn("wr3f", 0, 1'b0, 1'b1, 6'h3F, 32'h00000000, 32'h00000000);
    txn("rd3f", 1, 1'b1, 1'b0, 6'h3F, 32'h0, 32'h00000000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "time limit");
  end

endmodule
